send_flow_sched: RTL

SEND_FLOW_SCHED -- requirements
Module: send_flow_sched

---
 rtl/tcp_pkg.sv | 16 +
 rtl/rr_arb_2.sv | 41 ++++
 rtl/send_flow_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP engine sizes and types used by the send-side flow scheduler.
package tcp_pkg;

  localparam int FLOWID_W     = 5;
  localparam int MAX_FLOW_CNT = 32;
  localparam int SCHED_CNT_W  = $clog2(MAX_FLOW_CNT) + 1;

  typedef logic [FLOWID_W-1:0] flowid_t;

  // Requester identity for the two-way round-robin.
  typedef enum logic {
    GRANT_APP    = 1'b0,
    GRANT_RECIRC = 1'b1
  } grant_sel_e;

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester round-robin arbiter. Bit 0 is the app requester, bit 1 the
// recirc requester. Priority rotates only when the caller signals that the
// granted request was actually taken.
module rr_arb_2
  import tcp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  grant_sel_e last_q;
  grant_sel_e last_d;

  // Remember who won last; reset leaves recirc as last so app wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GRANT_RECIRC;
    end else begin
      last_q <= last_d;
    end
  end

  // One-hot grant with alternation on contention; history moves only on advance.
  always_comb begin
    grant_o = 2'b00;
    last_d  = last_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == GRANT_RECIRC) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (advance_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1] ? GRANT_RECIRC : GRANT_APP;
    end
  end

endmodule

// File: rtl/send_flow_sched.sv
// Send-side flow scheduler: arbitrates app and recirc scheduling requests,
// coalesces requests for flows already sitting in the scheduling FIFO, and
// tracks which flows are pending so a dequeue of an unknown flow is flagged.
module send_flow_sched
  import tcp_pkg::*;
#(
  parameter bit DEDUP_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   app_sched_req_val,
  input  logic [FLOWID_W-1:0]    app_sched_req_flowid,
  output logic                   sched_app_req_rdy,

  input  logic                   recirc_sched_req_val,
  input  logic [FLOWID_W-1:0]    recirc_sched_req_flowid,
  output logic                   sched_recirc_req_rdy,

  output logic                   sched_fifo_wr_req,
  output logic [FLOWID_W-1:0]    sched_fifo_wr_flowid,
  input  logic                   fifo_sched_wr_full,

  input  logic                   fifo_deq_val,
  input  logic [FLOWID_W-1:0]    fifo_deq_flowid,

  output logic [SCHED_CNT_W-1:0] sched_pending_cnt,
  output logic                   sched_deq_err
);

  logic                    out_val_q,  out_val_d;
  flowid_t                 out_flowid_q, out_flowid_d;
  logic [MAX_FLOW_CNT-1:0] pending_q,  pending_d;
  logic [SCHED_CNT_W-1:0]  cnt_q,      cnt_d;
  logic                    deq_err_q,  deq_err_d;

  logic                    load_en;
  logic [1:0]              arb_req;
  logic [1:0]              arb_grant;
  logic                    accept;
  flowid_t                 acc_flowid;
  logic [MAX_FLOW_CNT-1:0] pending_clr;
  logic                    coalesce;
  logic                    load;
  logic                    cnt_inc;
  logic                    cnt_dec;
  logic                    wr_fire;

  // The output register can take a new entry when empty or when draining now.
  assign load_en = !out_val_q || !fifo_sched_wr_full;
  assign arb_req = {recirc_sched_req_val, app_sched_req_val};

  rr_arb_2 u_rr_arb_2 (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .advance_i (accept),
    .grant_o   (arb_grant)
  );

  // Handshake, coalescing decision and next-state for bitmap, count and error.
  always_comb begin
    sched_app_req_rdy    = load_en && arb_grant[0] && !rst;
    sched_recirc_req_rdy = load_en && arb_grant[1] && !rst;
    wr_fire              = out_val_q && !fifo_sched_wr_full && !rst;

    accept     = (sched_app_req_rdy && app_sched_req_val) ||
                 (sched_recirc_req_rdy && recirc_sched_req_val);
    acc_flowid = arb_grant[1] ? recirc_sched_req_flowid : app_sched_req_flowid;

    // Dequeue clears first so a same-cycle re-request of that flow is enqueued.
    pending_clr = pending_q;
    if (fifo_deq_val) begin
      pending_clr[fifo_deq_flowid] = 1'b0;
    end

    coalesce = DEDUP_EN && pending_clr[acc_flowid];
    load     = accept && !coalesce;

    pending_d = pending_clr;
    if (load) begin
      pending_d[acc_flowid] = 1'b1;
    end

    cnt_dec = fifo_deq_val && pending_q[fifo_deq_flowid];
    cnt_inc = load && !pending_clr[acc_flowid];
    cnt_d   = cnt_q + SCHED_CNT_W'(cnt_inc) - SCHED_CNT_W'(cnt_dec);

    deq_err_d = deq_err_q || (fifo_deq_val && !pending_q[fifo_deq_flowid]);

    out_val_d    = out_val_q;
    out_flowid_d = out_flowid_q;
    if (load) begin
      out_val_d    = 1'b1;
      out_flowid_d = acc_flowid;
    end else if (wr_fire) begin
      out_val_d    = 1'b0;
    end
  end

  // State registers; reset drops any staged entry and all pending tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q    <= 1'b0;
      out_flowid_q <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
      deq_err_q    <= 1'b0;
    end else begin
      out_val_q    <= out_val_d;
      out_flowid_q <= out_flowid_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      deq_err_q    <= deq_err_d;
    end
  end

  assign sched_fifo_wr_req    = wr_fire;
  assign sched_fifo_wr_flowid = out_flowid_q;
  assign sched_pending_cnt    = cnt_q;
  assign sched_deq_err        = deq_err_q;

endmodule
